// File: rtl/ls198_seq_if.sv
// ls198_seq_if: command handshake plus LS198 control/feedback lines for ls198_seq.
`default_nettype none

interface ls198_seq_if;
    logic       start;
    logic [1:0] op;
    logic       dir;
    logic       fill;
    logic [3:0] count;
    logic [7:0] data;
    logic [7:0] Q;
    logic [1:0] S;
    logic       SR;
    logic       SL;
    logic [7:0] D;
    logic       busy;
    logic       done;

    modport master (
        output start, op, dir, fill, count, data, Q,
        input  S, SR, SL, D, busy, done
    );

    modport slave (
        input  start, op, dir, fill, count, data, Q,
        output S, SR, SL, D, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/ls198_seq.sv
// ls198_seq: one-command-at-a-time sequencer driving an LS198 shift register
// (load / shift right / shift left / rotate) with an optional per-step divider.
`default_nettype none

module ls198_seq #(
    parameter int STEP_DIV = 1
) (
    input  logic        CP,
    input  logic        CR,
    ls198_seq_if.slave  bus
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam int GAP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = (STEP_DIV > 1) ? GAP_W'(STEP_DIV - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        STEP = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t           state;
    logic [1:0]       mode;
    logic [1:0]       step_mode;
    logic [7:0]       d_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [1:0]       op_l;
    logic             dir_l;
    logic             fill_l;
    logic [3:0]       steps;
    logic [GAP_W-1:0] gap_cnt;
    logic             sr;
    logic             sl;
    logic             unused_q;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            mode      <= MODE_HOLD;
            step_mode <= MODE_HOLD;
            d_reg     <= 8'h00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            op_l      <= OP_LOAD;
            dir_l     <= 1'b0;
            fill_l    <= 1'b0;
            steps     <= 4'd0;
            gap_cnt   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_l   <= bus.op;
                        dir_l  <= bus.dir;
                        fill_l <= bus.fill;
                        if (bus.op == OP_LOAD) begin
                            state    <= LOAD;
                            mode     <= MODE_LOAD;
                            d_reg    <= bus.data;
                            busy_reg <= 1'b1;
                        end else if (bus.count == 4'd0) begin
                            done_reg <= 1'b1;
                        end else begin
                            // Rotate shares the shift-right/left modes; only the serial input differs.
                            if (bus.op == OP_SHR || (bus.op == OP_ROT && !bus.dir)) begin
                                mode      <= MODE_RIGHT;
                                step_mode <= MODE_RIGHT;
                            end else begin
                                mode      <= MODE_LEFT;
                                step_mode <= MODE_LEFT;
                            end
                            state    <= STEP;
                            steps    <= bus.count;
                            busy_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state    <= IDLE;
                    mode     <= MODE_HOLD;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                STEP: begin
                    steps <= steps - 4'd1;
                    if (STEP_DIV > 1) begin
                        state   <= GAP;
                        mode    <= MODE_HOLD;
                        gap_cnt <= GAP_INIT;
                    end else if (steps == 4'd1) begin
                        state    <= IDLE;
                        mode     <= MODE_HOLD;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (steps == 4'd0) begin
                        state    <= IDLE;
                        mode     <= MODE_HOLD;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        state <= STEP;
                        mode  <= step_mode;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mode     <= MODE_HOLD;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    // Serial inputs track Q combinationally so each rotate step sees the previous step's result.
    always_comb begin
        sr = 1'b0;
        sl = 1'b0;
        if (busy_reg) begin
            case (op_l)
                OP_SHR, OP_SHL: begin
                    sr = fill_l;
                    sl = fill_l;
                end
                OP_ROT: begin
                    if (dir_l) sl = bus.Q[7];
                    else       sr = bus.Q[0];
                end
                default: begin
                    sr = 1'b0;
                    sl = 1'b0;
                end
            endcase
        end
    end

    assign unused_q = ^bus.Q[6:1];

    assign bus.S    = mode;
    assign bus.SR   = sr;
    assign bus.SL   = sl;
    assign bus.D    = d_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_ls198_seq.sv
// tb_ls198_seq: drives two sequencers (STEP_DIV 1 and 3) with shared random commands,
// each feeding its own LS198 model, and scores completions against an arithmetic reference.
`default_nettype none

module tb_ls198_seq;

    typedef struct {
        logic [7:0] q;
        int         busy;
        int         act;
        logic [1:0] s;
        logic [7:0] d;
    } exp_t;

    logic       CP;
    logic       CR;
    logic       start;
    logic [1:0] op;
    logic       dir;
    logic       fill;
    logic [3:0] count;
    logic [7:0] data;
    logic [7:0] ls_q1;
    logic [7:0] ls_q3;
    logic [7:0] last_d;
    bit         in_reset;

    int   checks;
    int   errors;
    int   bcnt [2];
    int   acnt [2];
    exp_t sb1 [$];
    exp_t sb3 [$];

    ls198_seq_if bus1 ();
    ls198_seq_if bus3 ();

    ls198_seq #(.STEP_DIV(1)) dut1 (.CP(CP), .CR(CR), .bus(bus1.slave));
    ls198_seq #(.STEP_DIV(3)) dut3 (.CP(CP), .CR(CR), .bus(bus3.slave));

    assign bus1.start = start;  assign bus3.start = start;
    assign bus1.op    = op;     assign bus3.op    = op;
    assign bus1.dir   = dir;    assign bus3.dir   = dir;
    assign bus1.fill  = fill;   assign bus3.fill  = fill;
    assign bus1.count = count;  assign bus3.count = count;
    assign bus1.data  = data;   assign bus3.data  = data;
    assign bus1.Q     = ls_q1;
    assign bus3.Q     = ls_q3;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // External LS198 registers (not reset by CR)
    initial ls_q1 = 8'h00;
    initial ls_q3 = 8'h00;
    always @(posedge CP) begin
        case (bus1.S)
            2'b01:   ls_q1 <= {bus1.SR, ls_q1[7:1]};
            2'b10:   ls_q1 <= {ls_q1[6:0], bus1.SL};
            2'b11:   ls_q1 <= bus1.D;
            default: ls_q1 <= ls_q1;
        endcase
        case (bus3.S)
            2'b01:   ls_q3 <= {bus3.SR, ls_q3[7:1]};
            2'b10:   ls_q3 <= {ls_q3[6:0], bus3.SL};
            2'b11:   ls_q3 <= bus3.D;
            default: ls_q3 <= ls_q3;
        endcase
    end

    task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (STEP_DIV=%0d) t=%0t: got %0h, expected %0h", name, (i == 0) ? 1 : 3, $time, got, exp);
        end
    endtask

    // Reference: final register value and cycle budget from the command's meaning alone.
    function automatic exp_t model(input logic [1:0] o, input logic dr, input logic fl, input int n,
                                   input logic [7:0] dt, input logic [7:0] q8, input int div,
                                   input logic [7:0] prev_d);
        exp_t e;
        int   q;
        int   r;
        q      = int'(q8);
        e.d    = prev_d;
        e.q    = q8;
        e.busy = 0;
        e.act  = 0;
        e.s    = 2'b00;
        if (o == 2'b00) begin
            e.q = dt; e.d = dt; e.busy = 1; e.act = 1; e.s = 2'b11;
        end else if (n != 0) begin
            e.busy = n * div;
            e.act  = n;
            r      = n % 8;
            case (o)
                2'b01: e.q = 8'((q >> n) | (fl ? (255 & ~(255 >> n)) : 0));
                2'b10: e.q = 8'((q << n) | (fl ? ((1 << n) - 1) : 0));
                default: begin
                    if (dr) e.q = 8'((q << r) | (q >> (8 - r)));
                    else    e.q = 8'((q >> r) | (q << (8 - r)));
                end
            endcase
            e.s = (o == 2'b01 || (o == 2'b11 && !dr)) ? 2'b01 : 2'b10;
        end
        return e;
    endfunction

    task automatic monitor(input int i, input logic busy, input logic done, input logic [1:0] s,
                           input logic [7:0] d, input logic [7:0] q);
        exp_t e;
        bit   have;
        int   div;
        div  = (i == 0) ? 1 : 3;
        have = (i == 0) ? (sb1.size() > 0) : (sb3.size() > 0);
        if (have) e = (i == 0) ? sb1[0] : sb3[0];
        if (!busy) begin
            check("s_hold_when_idle", i, 32'(s), 32'd0);
        end else if (s != 2'b00) begin
            if (!have) begin
                check("activity_without_command", i, 32'd1, 32'd0);
            end else begin
                check("s_mode", i, 32'(s), 32'(e.s));
                check("s_first_cycle_of_step", i, 32'(bcnt[i] % div), 32'd0);
            end
            acnt[i]++;
        end
        if (busy) bcnt[i]++;
        if (done) begin
            check("busy_low_at_done", i, 32'(busy), 32'd0);
            if (!have) begin
                check("unexpected_done", i, 32'd1, 32'd0);
            end else begin
                if (i == 0) void'(sb1.pop_front());
                else        void'(sb3.pop_front());
                check("final_q", i, 32'(q), 32'(e.q));
                check("busy_cycles", i, 32'(bcnt[i]), 32'(e.busy));
                check("active_s_cycles", i, 32'(acnt[i]), 32'(e.act));
                check("d_value", i, 32'(d), 32'(e.d));
            end
            bcnt[i] = 0;
            acnt[i] = 0;
        end
    endtask

    always @(negedge CP) begin
        if (!in_reset) begin
            monitor(0, bus1.busy, bus1.done, bus1.S, bus1.D, ls_q1);
            monitor(1, bus3.busy, bus3.done, bus3.S, bus3.D, ls_q3);
        end
    end

    // Waits for both sequencers to be idle; while both are busy the inputs are scrambled,
    // exercising ignored starts and post-accept input changes.
    task automatic wait_idle();
        int  n;
        bit  idle;
        n    = 0;
        idle = 1'b0;
        while (!idle) begin
            @(negedge CP);
            if (!bus1.busy && !bus3.busy) begin
                idle = 1'b1;
            end else if (n > 200) begin
                check("idle_timeout", 0, 32'd1, 32'd0);
                idle = 1'b1;
            end else if (bus1.busy && bus3.busy) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                dir   = 1'($urandom_range(0, 1));
                fill  = 1'($urandom_range(0, 1));
                count = 4'($urandom_range(0, 15));
                data  = 8'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            n++;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic dr, input logic fl, input logic [3:0] c,
                         input logic [7:0] dt);
        wait_idle();
        start = 1'b1;
        op    = o;
        dir   = dr;
        fill  = fl;
        count = c;
        data  = dt;
        sb1.push_back(model(o, dr, fl, int'(c), dt, ls_q1, 1, last_d));
        sb3.push_back(model(o, dr, fl, int'(c), dt, ls_q3, 3, last_d));
        if (o == 2'b00) last_d = dt;
    endtask

    task automatic check_reset_outputs();
        check("rst_S",    0, 32'(bus1.S),    32'd0);  check("rst_S",    1, 32'(bus3.S),    32'd0);
        check("rst_busy", 0, 32'(bus1.busy), 32'd0);  check("rst_busy", 1, 32'(bus3.busy), 32'd0);
        check("rst_done", 0, 32'(bus1.done), 32'd0);  check("rst_done", 1, 32'(bus3.done), 32'd0);
        check("rst_D",    0, 32'(bus1.D),    32'd0);  check("rst_D",    1, 32'(bus3.D),    32'd0);
        check("rst_SR",   0, 32'(bus1.SR),   32'd0);  check("rst_SL",   1, 32'(bus3.SL),   32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        bcnt[0]  = 0; bcnt[1] = 0;
        acnt[0]  = 0; acnt[1] = 0;
        last_d   = 8'h00;
        in_reset = 1'b1;
        start = 1'b0; op = 2'b00; dir = 1'b0; fill = 1'b0; count = 4'd0; data = 8'h00;
        CR = 1'b0;
        #2 CR = 1'b1;
        #1 check_reset_outputs();
        @(negedge CP);
        @(posedge CP);
        #2 CR = 1'b0;
        @(negedge CP);
        in_reset = 1'b0;

        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'hA5);
        issue(2'b11, 1'b0, 1'b0, 4'd3, 8'h00);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h3C);
        issue(2'b10, 1'b0, 1'b1, 4'd4, 8'h00);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h81);
        issue(2'b01, 1'b0, 1'b0, 4'd2, 8'hFF);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h81);
        issue(2'b11, 1'b1, 1'b1, 4'd2, 8'h00);
        issue(2'b01, 1'b0, 1'b1, 4'd0, 8'h5A);
        issue(2'b11, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h66);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'h99);

        for (int k = 0; k < 70; k++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                  8'($urandom_range(0, 255)));
        end

        // Abort a count=5 shift during its second step.
        issue(2'b01, 1'b0, 1'b1, 4'd5, 8'h00);
        @(posedge CP);
        #1 start = 1'b0;
        @(posedge CP);
        #2;
        check("busy_before_abort", 0, 32'(bus1.busy), 32'd1);
        in_reset = 1'b1;
        CR = 1'b1;
        #1 check_reset_outputs();
        sb1.delete();
        sb3.delete();
        bcnt[0] = 0; bcnt[1] = 0;
        acnt[0] = 0; acnt[1] = 0;
        last_d  = 8'h00;
        @(negedge CP);
        @(posedge CP);
        #2 CR = 1'b0;
        @(negedge CP);
        in_reset = 1'b0;

        issue(2'b10, 1'b0, 1'b0, 4'd3, 8'h00);
        issue(2'b00, 1'b0, 1'b0, 4'd0, 8'hC3);
        for (int k = 0; k < 10; k++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        wait_idle();
        start = 1'b0;
        repeat (6) @(negedge CP);
        check("sb1_drained", 0, 32'(sb1.size()), 32'd0);
        check("sb3_drained", 1, 32'(sb3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ls198_seq.md
# ls198_seq

Sequencer that sits directly upstream of the LS198 8-bit bidirectional shift register. It accepts one command at a time (parallel load, shift right, shift left, rotate) over a start/busy/done handshake. It drives the LS198 mode lines S, serial inputs SR/SL and parallel data D, and reads back the register's Q for rotate feedback. Typical use is lab-board running-light and pattern demos, with an optional step divider to slow shifts to visible rates.

## Interface
- STEP_DIV, 1: cycles per shift step (>=1); S is non-hold for the first cycle of each step, 00 for the remaining STEP_DIV-1.
- CP  in  1  clock; all state changes on rising edge.
- CR  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- op  in  2  00 load, 01 shift right, 10 shift left, 11 rotate.
- dir  in  1  rotate direction: 0 right, 1 left (ignored for other ops).
- fill  in  1  serial fill bit for shift ops.
- count  in  4  number of shift/rotate steps, 0..15 (ignored for load).
- data  in  8  parallel load value.
- Q  in  8  current LS198 output (feedback).
- S  out  2  LS198 mode: 00 hold, 01 right, 10 left, 11 load.
- SR  out  1  LS198 right-shift serial input (enters Q[7]).
- SL  out  1  LS198 left-shift serial input (enters Q[0]).
- D  out  8  LS198 parallel data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, STEP, GAP. Registered state, S, D, busy, done, latched op/dir/fill/count, step counter and divider counter.
- IDLE: S=00. On start=1, op, dir, fill, count and data are latched. Input changes after acceptance are ignored until the next acceptance.
  - op=00: go to LOAD with S=11 and D=data.
  - op=01/10/11 with count>0: go to STEP with S=01 (shift right or rotate right) or S=10 (shift left or rotate left). Remaining steps = count.
  - op!=00 with count=0: no-op. Stay IDLE, busy stays 0, done=1 for one cycle.
- LOAD: one cycle, then IDLE, with S=00, busy=0, done=1.
- STEP: one cycle with S active. Decrement remaining steps.
  - If STEP_DIV>1: go to GAP with S=00 for STEP_DIV-1 cycles.
  - If STEP_DIV=1: stay in STEP.
  - When steps and the gap are exhausted: go to IDLE, S=00, busy=0, done=1.
- SR/SL are combinational from latched op/dir/fill and Q:
  - shift: SR=SL=fill.
  - rotate right: SR=Q[0].
  - rotate left: SL=Q[7].
  - all other times 0.
- D holds the last loaded value until the next load. After reset it is 0.
- start while busy=1 is ignored and produces no queueing. start in the done cycle is accepted normally, because busy=0.

## Timing
- Reset (CR=1, asynchronous, immediate): S=00, SR=0, SL=0, D=8'h00, busy=0, done=0, state IDLE, counters cleared. Reset mid-command aborts it with no done pulse. The LS198 sees hold from that point.
- Accept at edge k: busy=1 from edge k.
  - The LS198 acts on edges k+1..k+N*STEP_DIV, active only on the first edge of each step.
  - Load: N=1 and STEP_DIV is ignored; the LS198 loads at edge k+1.
- Completion: after edge k+N*STEP_DIV (load: k+1), busy=0, S=00, done=1 for exactly one cycle.
- Total busy cycles: 1 for load, N*STEP_DIV for shift/rotate. A new command is accepted at the earliest at edge k+N*STEP_DIV+1.
- No-op (count=0): done=1 in the cycle after edge k, and busy is never asserted.
- Rotate feedback: SR/SL follow Q within the same cycle, so each step uses the post-previous-step value.

## Test plan
- Reset and load: CR pulse, then start op=00 data=8'hA5. Required: S=11 for exactly 1 cycle, LS198 Q=8'hA5, busy high 1 cycle, done pulse 1 cycle, D=8'hA5 afterwards.
- Rotate right: Q=8'hA5, op=11 dir=0 count=3, STEP_DIV=1. Required: Q goes D2, 69, B4; busy 3 cycles; S=01 for 3 cycles, then 00.
- Shift left with fill: Q=8'h3C, op=10 fill=1 count=4. Required: Q goes 79, F3, E7, CF; done after 4th shift. Then op=01 fill=0 count=2 from 8'h81 gives 40, 20.
- Divider: STEP_DIV=3, rotate left count=2 from 8'h81. Required: S pattern 10,00,00,10,00,00; Q goes 03 then 06; busy 6 cycles.
- Handshake edges:
  - count=0: done pulse with no busy and Q unchanged.
  - start held high while busy: ignored.
  - start in the done cycle: accepted.
  - input change after accept: no effect.
- Mid-operation reset: CR=1 during step 2 of a count=5 shift. Required: S=00, busy=0, done=0, D=00 immediately; no done pulse; next start is accepted normally.
